// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: output widths, saturation
// ceilings, ISI arming states and the saturating increment used by every counter.
package snn_pkg;

  localparam int unsigned SPIKE_W = 8;
  localparam logic [SPIKE_W-1:0] RATE_MAX = 8'd255;
  localparam logic [SPIKE_W-1:0] ISI_MAX  = 8'd255;

  // One extra bit lets the window count distinguish "exactly 255" from "more".
  localparam int unsigned SCNT_W = 9;
  localparam logic [SCNT_W-1:0] SCNT_MAX = 9'd256;

  typedef enum logic {
    ISI_IDLE  = 1'b0,
    ISI_ARMED = 1'b1
  } isi_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? max : v + 16'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input, control and decoded-output bundle of the spike rate decoder.
interface spike_rate_decoder_if;

  logic                         ena;
  logic                         clear;
  logic                         spike_in;
  logic [snn_pkg::SPIKE_W-1:0]  rate;
  logic                         rate_sat;
  logic                         rate_valid;
  logic [snn_pkg::SPIKE_W-1:0]  isi;
  logic                         isi_valid;

  modport master (
    output ena, clear, spike_in,
    input  rate, rate_sat, rate_valid, isi, isi_valid
  );

  modport slave (
    input  ena, clear, spike_in,
    output rate, rate_sat, rate_valid, isi, isi_valid
  );

endinterface

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at MAX; clr wins over inc.
module sat_counter
  import snn_pkg::*;
#(
  parameter int unsigned  W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i) begin
      q_d = W'(sat_inc(16'(q_q), 16'(MAX)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a 1-bit spike train into a windowed spike-rate count and an
// inter-spike-interval measurement, both saturating at 255.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_rate_decoder_if.slave  bus
);

  logic                   spike_q;
  logic                   spk_edge;
  logic                   ena_edge;
  logic                   term;

  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [SCNT_W-1:0]      scnt;
  logic [SPIKE_W-1:0]     itim;
  logic [SCNT_W:0]        win_sum;

  logic [SPIKE_W-1:0]     rate_q, rate_d;
  logic                   rate_sat_q, rate_sat_d;
  logic                   rate_valid_q, rate_valid_d;
  logic [SPIKE_W-1:0]     isi_q, isi_d;
  logic                   isi_valid_q, isi_valid_d;
  isi_state_t             isi_state_q, isi_state_d;

  assign spk_edge = bus.spike_in & ~spike_q;
  assign ena_edge = bus.ena & spk_edge;
  assign term     = bus.ena & (wcnt_q == '1);

  // An edge on the terminal cycle is folded into the closing window's total
  // rather than the counter, which is being cleared on that same edge.
  assign win_sum  = {1'b0, scnt} + {{SCNT_W{1'b0}}, spk_edge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= bus.spike_in;
    end
  end

  sat_counter #(
    .W   (SCNT_W),
    .MAX (SCNT_MAX)
  ) u_scnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clear | term),
    .inc_i (ena_edge & ~term),
    .q_o   (scnt)
  );

  sat_counter #(
    .W   (SPIKE_W),
    .MAX (ISI_MAX)
  ) u_itim (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clear | ena_edge),
    .inc_i (bus.ena),
    .q_o   (itim)
  );

  always_comb begin
    wcnt_d       = wcnt_q;
    rate_d       = rate_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = 1'b0;
    if (bus.clear) begin
      wcnt_d = '0;
    end else if (bus.ena) begin
      wcnt_d = wcnt_q + 1'b1;
      if (term) begin
        rate_sat_d   = (win_sum > {2'b00, RATE_MAX});
        rate_d       = rate_sat_d ? RATE_MAX : win_sum[SPIKE_W-1:0];
        rate_valid_d = 1'b1;
      end
    end
  end

  // itim holds cycles since the previous edge minus one, hence the increment.
  always_comb begin
    isi_state_d = isi_state_q;
    isi_d       = isi_q;
    isi_valid_d = 1'b0;
    if (bus.clear) begin
      isi_state_d = ISI_IDLE;
    end else if (ena_edge) begin
      case (isi_state_q)
        ISI_IDLE: begin
          isi_state_d = ISI_ARMED;
        end
        ISI_ARMED: begin
          isi_d       = SPIKE_W'(sat_inc(16'(itim), 16'(ISI_MAX)));
          isi_valid_d = 1'b1;
        end
        default: begin
          isi_state_d = ISI_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q       <= '0;
      rate_q       <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_state_q  <= ISI_IDLE;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      rate_q       <= rate_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      isi_state_q  <= isi_state_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_sat   = rate_sat_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: a 256-cycle-window decoder for rate/ISI/clear/reset behaviour
// and a 1024-cycle-window decoder for count saturation.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spike_rate_decoder_if a_if ();
  spike_rate_decoder_if b_if ();

  spike_rate_decoder #(.WINDOW_LOG2(8)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  spike_rate_decoder #(.WINDOW_LOG2(10)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int a_rv, a_iv, b_rv, b_iv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_if.rate_valid === 1'b1) a_rv++;
    if (a_if.isi_valid === 1'b1)  a_iv++;
    if (b_if.rate_valid === 1'b1) b_rv++;
    if (b_if.isi_valid === 1'b1)  b_iv++;
  endtask

  task automatic zero_counts();
    a_rv = 0; a_iv = 0; b_rv = 0; b_iv = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.ena = 1'b0; a_if.clear = 1'b0; a_if.spike_in = 1'b0;
    b_if.ena = 1'b0; b_if.clear = 1'b0; b_if.spike_in = 1'b0;
    zero_counts();
    repeat (3) tick();

    check("rst_rate",       a_if.rate,       0);
    check("rst_rate_sat",   a_if.rate_sat,   0);
    check("rst_rate_valid", a_if.rate_valid, 0);
    check("rst_isi",        a_if.isi,        0);
    check("rst_isi_valid",  a_if.isi_valid,  0);

    // Idle window: one rate pulse on the 256th enabled cycle, no ISI.
    rst_n = 1'b1;
    a_if.ena = 1'b1;
    zero_counts();
    repeat (255) tick();
    check("idle_no_early_rv", a_rv, 0);
    tick();
    check("idle_rv",      a_if.rate_valid, 1);
    check("idle_rate",    a_if.rate,       0);
    check("idle_iv_none", a_iv,            0);

    // Periodic train: one spike every 8 cycles.
    zero_counts();
    for (int i = 0; i < 256; i++) begin
      a_if.spike_in = (i % 8 == 0);
      tick();
      if (i == 0) check("per_first_arms", a_if.isi_valid, 0);
      if (i == 8) begin
        check("per_isi_valid_8", a_if.isi_valid, 1);
        check("per_isi_8",       a_if.isi,       8);
      end
    end
    check("per_rv_cnt",   a_rv,            1);
    check("per_rv_term",  a_if.rate_valid, 1);
    check("per_rate",     a_if.rate,       32);
    check("per_rate_sat", a_if.rate_sat,   0);
    check("per_iv_cnt",   a_iv,            31);
    check("per_isi",      a_if.isi,        8);

    // Held spike counts once.
    zero_counts();
    for (int i = 0; i < 256; i++) begin
      a_if.spike_in = (i < 20);
      tick();
    end
    check("held_rv_cnt", a_rv,      1);
    check("held_rate",   a_if.rate, 1);
    check("held_iv_cnt", a_iv,      1);
    check("held_isi",    a_if.isi,  8);

    // Edge on the terminal cycle belongs to the closing window.
    zero_counts();
    for (int i = 0; i < 256; i++) begin
      a_if.spike_in = (i == 100 || i == 255);
      tick();
      if (i == 100) check("bnd_isi_gap_sat", a_if.isi, 255);
    end
    check("bnd_rv",        a_if.rate_valid, 1);
    check("bnd_rate",      a_if.rate,       2);
    check("bnd_isi_valid", a_if.isi_valid,  1);
    check("bnd_isi",       a_if.isi,        155);
    zero_counts();
    a_if.spike_in = 1'b0;
    repeat (256) tick();
    check("bnd_next_rv_cnt", a_rv,      1);
    check("bnd_next_rate",   a_if.rate, 0);

    // ena=0 stretch with spikes freezes everything.
    zero_counts();
    for (int i = 0; i < 10; i++) begin
      a_if.spike_in = (i == 0);
      tick();
    end
    check("ena_pre_isi", a_if.isi, 255);
    zero_counts();
    a_if.ena = 1'b0;
    for (int j = 0; j < 50; j++) begin
      a_if.spike_in = (j % 2 == 0);
      tick();
    end
    check("ena_off_rv",   a_rv,      0);
    check("ena_off_iv",   a_iv,      0);
    check("ena_off_rate", a_if.rate, 0);
    check("ena_off_isi",  a_if.isi,  255);
    a_if.ena = 1'b1;
    a_if.spike_in = 1'b1;
    tick();
    check("ena_resume_iv",  a_if.isi_valid, 1);
    check("ena_resume_isi", a_if.isi,       10);
    a_if.spike_in = 1'b0;
    zero_counts();
    repeat (244) tick();
    check("ena_win_no_early_rv", a_rv, 0);
    tick();
    check("ena_win_rv",   a_if.rate_valid, 1);
    check("ena_win_rate", a_if.rate,       2);

    // clear mid-window: aborted window gives nothing, next is full length.
    zero_counts();
    for (int i = 0; i < 100; i++) begin
      a_if.spike_in = (i == 50);
      tick();
    end
    a_if.spike_in = 1'b0;
    a_if.clear = 1'b1;
    tick();
    a_if.clear = 1'b0;
    check("clr_no_rv",    a_rv,      0);
    check("clr_rate_hold", a_if.rate, 2);
    check("clr_isi_hold", a_if.isi,  255);
    zero_counts();
    for (int i = 0; i < 255; i++) begin
      a_if.spike_in = (i == 5);
      tick();
    end
    a_if.spike_in = 1'b0;
    check("clr_win_no_early_rv", a_rv, 0);
    check("clr_first_edge_arms", a_iv, 0);
    tick();
    check("clr_win_rv",   a_if.rate_valid, 1);
    check("clr_win_rate", a_if.rate,       1);

    // rst_n mid-window: outputs clear at once, next window is full length.
    zero_counts();
    for (int i = 0; i < 100; i++) begin
      a_if.spike_in = (i == 20);
      tick();
    end
    a_if.spike_in = 1'b0;
    check("pre_rst_iv", a_iv, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rate",     a_if.rate,     0);
    check("mid_rst_isi",      a_if.isi,      0);
    check("mid_rst_rate_sat", a_if.rate_sat, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    zero_counts();
    for (int i = 0; i < 255; i++) begin
      a_if.spike_in = (i == 3);
      tick();
    end
    a_if.spike_in = 1'b0;
    check("rst_win_no_early_rv", a_rv,     0);
    check("rst_first_edge_arms", a_iv,     0);
    check("rst_isi_zero",        a_if.isi, 0);
    tick();
    check("rst_win_rv",   a_if.rate_valid, 1);
    check("rst_win_rate", a_if.rate,       1);

    // Saturation on the 1024-cycle window: 512 edges.
    zero_counts();
    b_if.ena = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      b_if.spike_in = (i % 2 == 0);
      tick();
    end
    b_if.spike_in = 1'b0;
    check("sat_no_early_rv", b_rv, 0);
    tick();
    check("sat_rv",       b_if.rate_valid, 1);
    check("sat_rate",     b_if.rate,       255);
    check("sat_rate_sat", b_if.rate_sat,   1);
    check("sat_iv_cnt",   b_iv,            511);
    check("sat_isi",      b_if.isi,        2);
    zero_counts();
    repeat (300) tick();
    b_if.spike_in = 1'b1;
    tick();
    b_if.spike_in = 1'b0;
    check("gap_iv",            b_if.isi_valid, 1);
    check("gap_isi",           b_if.isi,       255);
    check("gap_rate_sat_hold", b_if.rate_sat,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
